// File: rtl/if_prefetch.sv
// Instruction-fetch stage: keeps one memory access in flight and buffers
// fetched {pc,inst} pairs in a DEPTH-entry queue that feeds ID.
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = '0,
    parameter bit          BR_HOLD  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        use_npc,
    input  logic [31:0] npc_addr,
    input  logic        br_resolved,
    input  logic [4:0]  stall,
    input  logic [31:0] ram_inst,
    input  logic        ram_inst_busy,
    output logic        ram_inst_re,
    output logic [31:0] ram_inst_addr,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        stall_req
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t CNT_MAX = cnt_t'(DEPTH);

    logic [31:0] q_pc   [DEPTH];
    logic [31:0] q_inst [DEPTH];

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        re_q, re_d;
    logic        hold_q, hold_d;
    logic        stale_q, stale_d;
    logic        valid_q, valid_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;

    logic done;
    logic push;
    logic pop;
    logic unused_stall;

    assign unused_stall = ^stall[4:1];
    assign done         = re_q && !ram_inst_busy;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        re_d       = re_q;
        hold_d     = hold_q;
        stale_d    = stale_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (rdy) begin
            if (use_npc) begin
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
                inst_d     = '0;
                valid_d    = 1'b0;
                hold_d     = 1'b0;
                fetch_pc_d = npc_addr;
                // A still-pending access must finish on the bus; its data is dropped later.
                if (re_q && ram_inst_busy) begin
                    stale_d = 1'b1;
                end else begin
                    stale_d = 1'b0;
                    re_d    = 1'b1;
                    addr_d  = npc_addr;
                end
            end else begin
                push = done && !stale_q;
                pop  = !stall[0] && (count_q != '0);

                if (done && stale_q) begin
                    stale_d = 1'b0;
                end
                if (BR_HOLD && br_resolved) begin
                    hold_d = 1'b0;
                end
                if (push) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    tail_d     = tail_q + PTR_ONE;
                    if (BR_HOLD && (ram_inst[6:4] == 3'b110)) begin
                        hold_d = 1'b1;
                    end
                end

                if (pop) begin
                    pc_d    = q_pc[head_q];
                    inst_d  = q_inst[head_q];
                    valid_d = 1'b1;
                    head_d  = head_q + PTR_ONE;
                end else if (!stall[0]) begin
                    inst_d  = '0;
                    valid_d = 1'b0;
                end

                if (push && !pop) begin
                    count_d = count_q + CNT_ONE;
                end else if (pop && !push) begin
                    count_d = count_q - CNT_ONE;
                end

                if (!re_q || done) begin
                    re_d = !hold_d && (count_d < CNT_MAX);
                    if (re_d) begin
                        addr_d = fetch_pc_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= '1;
            pc_q       <= '0;
            inst_q     <= '0;
            re_q       <= 1'b0;
            hold_q     <= 1'b0;
            stale_q    <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            re_q       <= re_d;
            hold_q     <= hold_d;
            stale_q    <= stale_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail_q]   <= fetch_pc_q;
            q_inst[tail_q] <= ram_inst;
        end
    end

    assign ram_inst_re   = re_q;
    assign ram_inst_addr = addr_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign inst_valid    = valid_q;
    assign stall_req     = (count_q == '0);

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: cycle vector table, hold/reset sequences,
// and a randomized stream checked against an in-order pc/instruction model.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy;
    logic        use_npc;
    logic [31:0] npc_addr;
    logic        br_resolved;
    logic [4:0]  stall;
    logic [31:0] ram_inst;
    logic        ram_inst_busy;
    logic        ram_inst_re;
    logic [31:0] ram_inst_addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall_req;

    logic [31:0] br_addr = 32'h1;

    int unsigned passed = 0;
    int unsigned total  = 0;

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .BR_HOLD  (1'b1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .use_npc       (use_npc),
        .npc_addr      (npc_addr),
        .br_resolved   (br_resolved),
        .stall         (stall),
        .ram_inst      (ram_inst),
        .ram_inst_busy (ram_inst_busy),
        .ram_inst_re   (ram_inst_re),
        .ram_inst_addr (ram_inst_addr),
        .pc            (pc),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    // Memory contents: a hash of the address with opcode[6:4] kept away from
    // 3'b110, except for one selectable branch location.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == br_addr) return 32'h0000_006F;
        return ((a * 32'h9E37_79B1) ^ 32'h1357_2468) & ~32'h0000_0070;
    endfunction

    assign ram_inst = inst_of(ram_inst_addr);

    typedef struct {
        logic        rdy;
        logic        busy;
        logic        st0;
        logic        npc_v;
        logic [31:0] npc;
        logic        e_re;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_sreq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic b, input logic s, input logic n,
                       input logic [31:0] na, input logic ere, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic es);
        vec_t v;
        v = '{r, b, s, n, na, ere, ea, ev, ep, es};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic b, input logic s0, input logic n,
                         input logic [31:0] na, input logic brr);
        rdy           = r;
        ram_inst_busy = b;
        stall         = {4'($urandom_range(0, 15)), s0};
        use_npc       = n;
        npc_addr      = na;
        br_resolved   = brr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic        saw14, seen_br, found, r, b, s0, n, brr;
    logic [31:0] exp_pc, na;
    int unsigned delivered;

    initial begin
        // Cycle-by-cycle table starting at the first edge after reset.
        add(1,1,0,0,32'h0,        1,32'h0,        0,32'h0,        1);
        add(1,1,0,0,32'h0,        1,32'h0,        0,32'h0,        1);
        add(1,0,0,0,32'h0,        1,32'h4,        0,32'h0,        0);
        add(1,1,0,0,32'h0,        1,32'h4,        1,32'h0,        1);
        add(1,0,0,0,32'h0,        1,32'h8,        0,32'h0,        0);
        add(1,0,1,0,32'h0,        1,32'hC,        0,32'h0,        0);
        add(1,0,1,0,32'h0,        1,32'h10,       0,32'h0,        0);
        add(1,0,1,0,32'h0,        0,32'h10,       0,32'h0,        0);
        add(1,0,1,0,32'h0,        0,32'h10,       0,32'h0,        0);
        add(1,0,0,0,32'h0,        1,32'h14,       1,32'h4,        0);
        add(1,1,0,0,32'h0,        1,32'h14,       1,32'h8,        0);
        add(0,0,0,1,32'h300,      1,32'h14,       1,32'h8,        0);
        add(0,0,0,1,32'h300,      1,32'h14,       1,32'h8,        0);
        add(0,0,0,1,32'h300,      1,32'h14,       1,32'h8,        0);
        add(1,1,0,1,32'h100,      1,32'h14,       0,32'h8,        1);
        add(1,0,0,0,32'h0,        1,32'h100,      0,32'h8,        1);
        add(1,0,0,0,32'h0,        1,32'h104,      0,32'h8,        0);
        add(1,1,0,0,32'h0,        1,32'h104,      1,32'h100,      1);
        add(1,0,0,0,32'h0,        1,32'h108,      0,32'h100,      0);
        add(1,0,0,1,32'h200,      1,32'h200,      0,32'h100,      1);
        add(1,1,0,0,32'h0,        1,32'h200,      0,32'h100,      1);
        add(1,0,0,0,32'h0,        1,32'h204,      0,32'h100,      0);
        add(1,1,0,0,32'h0,        1,32'h204,      1,32'h200,      1);
        add(1,1,0,1,32'hFFFFFFFC, 1,32'h204,      0,32'h200,      1);
        add(1,0,0,0,32'h0,        1,32'hFFFFFFFC, 0,32'h200,      1);
        add(1,0,0,0,32'h0,        1,32'h0,        0,32'h200,      0);
        add(1,0,0,0,32'h0,        1,32'h4,        1,32'hFFFFFFFC, 0);
        add(1,1,0,0,32'h0,        1,32'h4,        1,32'h0,        1);

        do_reset();
        chk("reset re", ram_inst_re, 0);
        chk("reset addr", ram_inst_addr, 32'hFFFFFFFF);
        chk("reset valid", inst_valid, 0);
        chk("reset pc", pc, 0);
        chk("reset inst", inst, 0);
        chk("reset stall_req", stall_req, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rdy, tbl[i].busy, tbl[i].st0, tbl[i].npc_v, tbl[i].npc, 1'b0);
            step();
            chk($sformatf("row%0d re", i), ram_inst_re, tbl[i].e_re);
            chk($sformatf("row%0d addr", i), ram_inst_addr, tbl[i].e_addr);
            chk($sformatf("row%0d valid", i), inst_valid, tbl[i].e_valid);
            chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("row%0d inst", i), inst,
                tbl[i].e_valid ? inst_of(tbl[i].e_pc) : 32'h0);
            chk($sformatf("row%0d stall_req", i), stall_req, tbl[i].e_sreq);
        end

        // Branch at 0x10 stops sequential fetch until br_resolved.
        br_addr = 32'h10;
        do_reset();
        saw14 = 1'b0;
        seen_br = 1'b0;
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            step();
            if (ram_inst_re && ram_inst_addr == 32'h14) saw14 = 1'b1;
            if (inst_valid && pc == 32'h10 && inst == 32'h6F) seen_br = 1'b1;
        end
        chk("hold no fetch 0x14", saw14, 0);
        chk("hold branch delivered", seen_br, 1);
        chk("hold re low", ram_inst_re, 0);
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, c == 0);
            step();
            if (ram_inst_re) found = 1'b1;
        end
        chk("resolve re", found, 1);
        chk("resolve addr", ram_inst_addr, 32'h14);

        // Redirect while held (with br_resolved asserted too): redirect wins.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            step();
        end
        chk("hold2 re low", ram_inst_re, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
        step();
        chk("hold redirect re", ram_inst_re, 1);
        chk("hold redirect addr", ram_inst_addr, 32'h40);
        chk("hold redirect valid", inst_valid, 0);
        br_addr = 32'h1;

        // Asynchronous reset in the middle of a pending access.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("pre-areset re", ram_inst_re, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("areset re", ram_inst_re, 0);
        chk("areset addr", ram_inst_addr, 32'hFFFFFFFF);
        chk("areset valid", inst_valid, 0);
        chk("areset stall_req", stall_req, 1);
        step();
        rst = 1'b1;
        step();
        chk("post-reset re", ram_inst_re, 1);
        chk("post-reset addr", ram_inst_addr, 32'h0);

        // Random stream: delivered instructions must follow the program order
        // from the last redirect target, with matching memory contents.
        do_reset();
        exp_pc = 32'h0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 9) != 0);
            b   = 1'($urandom_range(0, 1));
            s0  = ($urandom_range(0, 3) == 0);
            n   = ($urandom_range(0, 29) == 0);
            na  = $urandom & 32'hFFFF_FFFC;
            brr = ($urandom_range(0, 7) == 0);
            drive(r, b, s0, n, na, brr);
            step();
            if (r && n) begin
                exp_pc = na;
                chk("rnd redirect valid", inst_valid, 0);
            end else if (r && !s0) begin
                if (inst_valid) begin
                    chk("rnd pc", pc, exp_pc);
                    chk("rnd inst", inst, inst_of(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end else begin
                    chk("rnd empty inst", inst, 0);
                end
            end
        end
        chk("rnd progress", (delivered > 100), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
